// File: rtl/network_interface_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : network_interface_tx_pkg
// Description : Flit encoding shared by the transmit network interface, the
//               router Port and the receive network interface. It holds the
//               flit type codes, the position of the type field, the HEAD
//               flit field offsets and the packetizer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package network_interface_tx_pkg;

  // Flit type codes. They sit in the top TYPE_WIDTH bits of every flit.
  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_BODY = 2'b10;
  localparam logic [1:0] FLIT_TAIL = 2'b11;

  // HEAD flit layout: destination at the LSBs, source directly above it.
  localparam int HEAD_DEST_LSB = 0;

  // Bit position of the MSB of the type field for a given flit width.
  function automatic int type_msb(input int data_width);
    return data_width - 1;
  endfunction

  // LSB of the source field in a HEAD flit.
  function automatic int head_src_lsb(input int request_width);
    return HEAD_DEST_LSB + request_width;
  endfunction

  // Packetizer state encoding.
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PAYLOAD = 1'b1;

endpackage : network_interface_tx_pkg
`default_nettype wire

// File: rtl/network_interface_tx_flit_out_reg.sv
`default_nettype none
// ============================================================================
// Module      : network_interface_tx_flit_out_reg
// Description : Single-entry valid/ready output register. A new word is
//               captured whenever the slot is free and i_load is high. While
//               the held word is stalled (o_valid && !i_ready), data and valid
//               stay stable.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               i_load       - capture i_data (only honoured when slot free)
//               i_data       - word to capture
//               i_ready      - downstream ready
//               o_data       - registered word
//               o_valid      - registered word valid
//               o_slot_free  - register can take a new word this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module network_interface_tx_flit_out_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_slot_free
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // Free when empty or when the current word leaves this cycle; this lets a
  // new word replace the departing one with no bubble.
  assign o_slot_free = !r_valid || i_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (o_slot_free) begin
      if (i_load) begin
        r_data  <= i_data;
        r_valid <= 1'b1;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule : network_interface_tx_flit_out_reg
`default_nettype wire

// File: rtl/network_interface_tx.sv
`default_nettype none
// ============================================================================
// Module      : network_interface_tx
// Description : Packetizer between a processing node and a router input
//               port. Accepts a destination, then FlitPerPacket-1 payload
//               words, and emits HEAD, BODY..., TAIL flits through a single
//               registered output stage at one flit per cycle.
// Ports       : clk, rst                     - clock, sync active-high reset
//               dest_in/dest_valid/dest_ready - destination handshake
//               payload_in/_valid/_ready      - payload word handshake
//               data_out/valid_out/ready_out  - flit stream to router
//               busy                          - packet in progress
//               packets_sent                  - TAIL flits accepted (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module network_interface_tx
  import network_interface_tx_pkg::*;
#(
  parameter int N             = 2,
  parameter int INDEX         = 1,
  parameter int DATA_WIDTH    = 32,
  parameter int TYPE_WIDTH    = 2,
  parameter int REQUEST_WIDTH = 1,
  parameter int FlitPerPacket = 6,
  parameter int PhitPerFlit   = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [REQUEST_WIDTH-1:0]         dest_in,
  input  logic                             dest_valid,
  output logic                             dest_ready,
  input  logic [DATA_WIDTH-TYPE_WIDTH-1:0] payload_in,
  input  logic                             payload_valid,
  output logic                             payload_ready,
  output logic [DATA_WIDTH-1:0]            data_out,
  output logic                             valid_out,
  input  logic                             ready_out,
  output logic                             busy,
  output logic [15:0]                      packets_sent
);

  localparam int TYPE_MSB  = type_msb(DATA_WIDTH);
  localparam int SRC_LSB   = head_src_lsb(REQUEST_WIDTH);
  localparam int CNT_WIDTH = $clog2(FlitPerPacket);
  // Payload words with cnt below this value are BODY; the rest is TAIL.
  localparam int LAST_BODY = FlitPerPacket - 2;

  generate
    if (FlitPerPacket < 2 || PhitPerFlit != 1 || INDEX >= N ||
        DATA_WIDTH < TYPE_WIDTH + 2 * REQUEST_WIDTH) begin : g_bad_params
      $error("network_interface_tx: unsupported parameter combination");
    end
  endgenerate

  logic [0:0]            r_state;
  logic [0:0]            w_state_next;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [15:0]           r_packets_sent;
  logic                  w_slot_free;
  logic                  w_dest_hs;
  logic                  w_payload_hs;
  logic                  w_is_tail;
  logic                  w_load;
  logic [DATA_WIDTH-1:0] w_head;
  logic [DATA_WIDTH-1:0] w_payload_flit;
  logic [DATA_WIDTH-1:0] w_flit;
  logic [TYPE_WIDTH-1:0] w_payload_type;
  logic [TYPE_WIDTH-1:0] w_out_type;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_dest_hs) w_state_next = ST_PAYLOAD;
      ST_PAYLOAD: if (w_payload_hs && w_is_tail) w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. Both readies are forced low while rst is high so nothing
  // is accepted in the reset cycle itself.
  // --------------------------------------------------------------------------
  always_comb begin
    dest_ready    = 1'b0;
    payload_ready = 1'b0;
    case (r_state)
      ST_IDLE:    dest_ready    = w_slot_free && !rst;
      ST_PAYLOAD: payload_ready = w_slot_free && !rst;
      default:    ;
    endcase
  end

  assign w_dest_hs    = dest_valid && dest_ready;
  assign w_payload_hs = payload_valid && payload_ready;
  assign w_is_tail    = !(int'(r_cnt) < LAST_BODY);
  assign w_load       = w_dest_hs || w_payload_hs;

  // --------------------------------------------------------------------------
  // Flit assembly
  // --------------------------------------------------------------------------
  always_comb begin
    w_head                                  = '0;
    w_head[TYPE_MSB -: TYPE_WIDTH]          = TYPE_WIDTH'(FLIT_HEAD);
    w_head[HEAD_DEST_LSB +: REQUEST_WIDTH]  = dest_in;
    w_head[SRC_LSB +: REQUEST_WIDTH]        = REQUEST_WIDTH'(INDEX);
  end

  assign w_payload_type = w_is_tail ? TYPE_WIDTH'(FLIT_TAIL) : TYPE_WIDTH'(FLIT_BODY);
  assign w_payload_flit = {w_payload_type, payload_in};
  assign w_flit         = w_dest_hs ? w_head : w_payload_flit;

  // --------------------------------------------------------------------------
  // Payload word counter, restarted by each accepted destination
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_dest_hs) begin
      r_cnt <= '0;
    end else if (w_payload_hs) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  network_interface_tx_flit_out_reg #(
    .WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_load),
    .i_data      (w_flit),
    .i_ready     (ready_out),
    .o_data      (data_out),
    .o_valid     (valid_out),
    .o_slot_free (w_slot_free)
  );

  // --------------------------------------------------------------------------
  // Completed-packet counter: counts TAIL flits taken by the router
  // --------------------------------------------------------------------------
  assign w_out_type = data_out[TYPE_MSB -: TYPE_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_packets_sent <= '0;
    end else if (valid_out && ready_out && w_out_type == TYPE_WIDTH'(FLIT_TAIL)) begin
      r_packets_sent <= r_packets_sent + 16'd1;
    end
  end

  assign packets_sent = r_packets_sent;
  assign busy         = (r_state != ST_IDLE) || valid_out;

endmodule : network_interface_tx
`default_nettype wire

// File: tb/tb_network_interface_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_network_interface_tx
// Description : Self-checking bench for network_interface_tx. A six-flit
//               instance is driven from a per-cycle vector table (normal
//               packet, output stall, back-to-back packets, payload bubbles),
//               followed by a mid-packet reset sequence. A two-flit instance
//               covers the HEAD-then-TAIL case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_network_interface_tx;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;

  // Six-flit instance
  logic [0:0]  dest_in;
  logic        dest_valid, dest_ready;
  logic [29:0] payload_in;
  logic        payload_valid, payload_ready;
  logic [31:0] data_out;
  logic        valid_out, ready_out, busy;
  logic [15:0] packets_sent;

  // Two-flit instance
  logic [0:0]  b_dest_in;
  logic        b_dest_valid, b_dest_ready;
  logic [29:0] b_payload_in;
  logic        b_payload_valid, b_payload_ready;
  logic [31:0] b_data_out;
  logic        b_valid_out, b_ready_out, b_busy;
  logic [15:0] b_packets_sent;

  always #5 clk = ~clk;

  network_interface_tx u_dut (
    .clk           (clk),
    .rst           (rst),
    .dest_in       (dest_in),
    .dest_valid    (dest_valid),
    .dest_ready    (dest_ready),
    .payload_in    (payload_in),
    .payload_valid (payload_valid),
    .payload_ready (payload_ready),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .ready_out     (ready_out),
    .busy          (busy),
    .packets_sent  (packets_sent)
  );

  network_interface_tx #(
    .FlitPerPacket (2)
  ) u_dut2 (
    .clk           (clk),
    .rst           (rst),
    .dest_in       (b_dest_in),
    .dest_valid    (b_dest_valid),
    .dest_ready    (b_dest_ready),
    .payload_in    (b_payload_in),
    .payload_valid (b_payload_valid),
    .payload_ready (b_payload_ready),
    .data_out      (b_data_out),
    .valid_out     (b_valid_out),
    .ready_out     (b_ready_out),
    .busy          (b_busy),
    .packets_sent  (b_packets_sent)
  );

  typedef struct {
    logic        dv;
    logic [0:0]  dest;
    logic        pv;
    logic [29:0] pl;
    logic        ro;
    logic        ev;
    logic [31:0] ed;
    logic        edr;
    logic        epr;
    logic [15:0] ep;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic dv, input logic dest, input logic pv,
                     input logic [29:0] pl, input logic ro, input logic ev,
                     input logic [31:0] ed, input logic edr, input logic epr,
                     input logic [15:0] ep);
    vec_t v;
    v.dv = dv; v.dest = dest; v.pv = pv; v.pl = pl; v.ro = ro;
    v.ev = ev; v.ed = ed; v.edr = edr; v.epr = epr; v.ep = ep;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    dest_in = '0; dest_valid = 0; payload_in = '0; payload_valid = 0; ready_out = 1;
    b_dest_in = '0; b_dest_valid = 0; b_payload_in = '0; b_payload_valid = 0; b_ready_out = 1;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    #2;
    chk("rst_dest_ready", 32'(dest_ready), 32'd0);
    chk("rst_payload_ready", 32'(payload_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("init_valid", 32'(valid_out), 32'd0);
    chk("init_data", data_out, 32'd0);
    chk("init_busy", 32'(busy), 32'd0);
    chk("init_pkts", 32'(packets_sent), 32'd0);
    chk("init_dest_ready", 32'(dest_ready), 32'd1);
    chk("init_payload_ready", 32'(payload_ready), 32'd0);
    chk("init_b_valid", 32'(b_valid_out), 32'd0);

    // ---- vector table: dv dest pv pl ro | ev data dr pr pkts ----
    // Packet 1: dest 0, payloads 1..5, no stalls
    add(1,0,0,30'h0,1, 0,32'h0,       1,0,0);
    add(0,0,1,30'h1,1, 1,32'h40000002,0,1,0);
    add(0,0,1,30'h2,1, 1,32'h80000001,0,1,0);
    add(0,0,1,30'h3,1, 1,32'h80000002,0,1,0);
    add(0,0,1,30'h4,1, 1,32'h80000003,0,1,0);
    add(0,0,1,30'h5,1, 1,32'h80000004,0,1,0);
    add(0,0,0,30'h0,1, 1,32'hC0000005,1,0,0);
    add(0,0,0,30'h0,1, 0,32'h0,       1,0,1);
    // Packet 2: router stalls 3 cycles on 0x80000002
    add(1,0,0,30'h0,1, 0,32'h0,       1,0,1);
    add(0,0,1,30'h1,1, 1,32'h40000002,0,1,1);
    add(0,0,1,30'h2,1, 1,32'h80000001,0,1,1);
    add(0,0,1,30'h3,0, 1,32'h80000002,0,0,1);
    add(0,0,1,30'h3,0, 1,32'h80000002,0,0,1);
    add(0,0,1,30'h3,0, 1,32'h80000002,0,0,1);
    add(0,0,1,30'h3,1, 1,32'h80000002,0,1,1);
    add(0,0,1,30'h4,1, 1,32'h80000003,0,1,1);
    add(0,0,1,30'h5,1, 1,32'h80000004,0,1,1);
    add(0,0,0,30'h0,1, 1,32'hC0000005,1,0,1);
    add(0,0,0,30'h0,1, 0,32'h0,       1,0,2);
    // Packets 3+4: dest_valid held, back-to-back, payload ignored in IDLE
    add(1,1,0,30'h0, 1, 0,32'h0,       1,0,2);
    add(1,1,1,30'h11,1, 1,32'h40000003,0,1,2);
    add(1,1,1,30'h12,1, 1,32'h80000011,0,1,2);
    add(1,1,1,30'h13,1, 1,32'h80000012,0,1,2);
    add(1,1,1,30'h14,1, 1,32'h80000013,0,1,2);
    add(1,1,1,30'h15,1, 1,32'h80000014,0,1,2);
    add(1,1,1,30'h21,1, 1,32'hC0000015,1,0,2);
    add(1,1,1,30'h21,1, 1,32'h40000003,0,1,3);
    add(1,1,1,30'h22,1, 1,32'h80000021,0,1,3);
    add(1,1,1,30'h23,1, 1,32'h80000022,0,1,3);
    add(1,1,1,30'h24,1, 1,32'h80000023,0,1,3);
    add(1,1,1,30'h25,1, 1,32'h80000024,0,1,3);
    add(0,0,0,30'h0, 1, 1,32'hC0000025,1,0,3);
    add(0,0,0,30'h0, 1, 0,32'h0,       1,0,4);
    // Packet 5: payload_valid with 2-cycle bubbles
    add(1,0,0,30'h0,1, 0,32'h0,       1,0,4);
    add(0,0,1,30'h1,1, 1,32'h40000002,0,1,4);
    add(0,0,0,30'h0,1, 1,32'h80000001,0,1,4);
    add(0,0,0,30'h0,1, 0,32'h0,       0,1,4);
    add(0,0,1,30'h2,1, 0,32'h0,       0,1,4);
    add(0,0,0,30'h0,1, 1,32'h80000002,0,1,4);
    add(0,0,0,30'h0,1, 0,32'h0,       0,1,4);
    add(0,0,1,30'h3,1, 0,32'h0,       0,1,4);
    add(0,0,0,30'h0,1, 1,32'h80000003,0,1,4);
    add(0,0,0,30'h0,1, 0,32'h0,       0,1,4);
    add(0,0,1,30'h4,1, 0,32'h0,       0,1,4);
    add(0,0,0,30'h0,1, 1,32'h80000004,0,1,4);
    add(0,0,0,30'h0,1, 0,32'h0,       0,1,4);
    add(0,0,1,30'h5,1, 0,32'h0,       0,1,4);
    add(0,0,0,30'h0,1, 1,32'hC0000005,1,0,4);
    add(0,0,0,30'h0,1, 0,32'h0,       1,0,5);

    foreach (vecs[i]) begin
      @(negedge clk);
      dest_valid    = vecs[i].dv;
      dest_in       = vecs[i].dest;
      payload_valid = vecs[i].pv;
      payload_in    = vecs[i].pl;
      ready_out     = vecs[i].ro;
      #2;
      chk($sformatf("v%0d_valid", i), 32'(valid_out), 32'(vecs[i].ev));
      if (vecs[i].ev)
        chk($sformatf("v%0d_data", i), data_out, vecs[i].ed);
      chk($sformatf("v%0d_dest_ready", i), 32'(dest_ready), 32'(vecs[i].edr));
      chk($sformatf("v%0d_payload_ready", i), 32'(payload_ready), 32'(vecs[i].epr));
      chk($sformatf("v%0d_pkts", i), 32'(packets_sent), 32'(vecs[i].ep));
    end

    // ---- reset after three flits accepted ----
    @(negedge clk); dest_valid = 1; dest_in = 0; payload_valid = 0; ready_out = 1;
    @(negedge clk); dest_valid = 0; payload_valid = 1; payload_in = 30'h1;
    @(negedge clk); payload_in = 30'h2;
    @(negedge clk); payload_in = 30'h3;
    #2;
    chk("mid_busy", 32'(busy), 32'd1);
    @(negedge clk); rst = 1'b1;
    #2;
    chk("inrst_dest_ready", 32'(dest_ready), 32'd0);
    chk("inrst_payload_ready", 32'(payload_ready), 32'd0);
    @(negedge clk); rst = 1'b0; payload_valid = 0; dest_valid = 1; dest_in = 1;
    #2;
    chk("postrst_valid", 32'(valid_out), 32'd0);
    chk("postrst_busy", 32'(busy), 32'd0);
    chk("postrst_pkts", 32'(packets_sent), 32'd0);
    chk("postrst_dest_ready", 32'(dest_ready), 32'd1);
    @(negedge clk); dest_valid = 0; payload_valid = 1; payload_in = 30'h31;
    #2;
    chk("postrst_head_valid", 32'(valid_out), 32'd1);
    chk("postrst_head", data_out, 32'h40000003);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      payload_valid = (k < 5);
      payload_in    = 30'(32'h31 + k);
      #2;
      chk($sformatf("postrst_flit%0d", k), data_out,
          ((k < 5) ? 32'h80000000 : 32'hC0000000) | (32'h30 + 32'(k)));
    end
    @(negedge clk);
    #2;
    chk("postrst_end_valid", 32'(valid_out), 32'd0);
    chk("postrst_end_pkts", 32'(packets_sent), 32'd1);

    // ---- two-flit packets: HEAD then TAIL directly ----
    @(negedge clk); b_dest_valid = 1; b_dest_in = 1;
    #2;
    chk("fp2_dest_ready", 32'(b_dest_ready), 32'd1);
    @(negedge clk); b_dest_valid = 0; b_payload_valid = 1; b_payload_in = 30'h7;
    #2;
    chk("fp2_head", b_data_out, 32'h40000003);
    chk("fp2_payload_ready", 32'(b_payload_ready), 32'd1);
    @(negedge clk); b_payload_valid = 0;
    #2;
    chk("fp2_tail_valid", 32'(b_valid_out), 32'd1);
    chk("fp2_tail", b_data_out, 32'hC0000007);
    @(negedge clk);
    #2;
    chk("fp2_end_valid", 32'(b_valid_out), 32'd0);
    chk("fp2_pkts", 32'(b_packets_sent), 32'd1);
    chk("fp2_busy", 32'(b_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_network_interface_tx
`default_nettype wire
